// File: rtl/buf_pkg.sv
//------------------------------------------------------------------------------
// Module  : buf_pkg
// Brief   : Defaults and the pointer-width helper for the systolic buffers.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package buf_pkg;
  localparam int BUF_WIDTH_DEF  = 8;
  localparam int BUF_DEPTH_DEF  = 8;
  localparam int BUF_MAXPAD_DEF = 7;

  // One extra MSB lets a full FIFO be told apart from an empty one after a wrap.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/outbuf_deskew_line.sv
//------------------------------------------------------------------------------
// Module  : deskew_line
// Brief   : {valid,data} shift register of STAGES cycles; STAGES=0 is a wire.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module deskew_line #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout
);

  if (STAGES == 0) begin : g_wire
    logic w_unused_clk;
    assign w_unused_clk = clk;
    // A word arriving on a clearing edge is discarded even with no stages.
    assign out_valid = in_valid && !rst && !clr;
    assign dout      = din;
  end else begin : g_pipe
    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_d [STAGES];

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        r_v <= '0;
      end else begin
        r_v[0] <= in_valid;
        for (int i = 1; i < STAGES; i++) r_v[i] <= r_v[i-1];
      end
    end

    always_ff @(posedge clk) begin
      r_d[0] <= din;
      for (int i = 1; i < STAGES; i++) r_d[i] <= r_d[i-1];
    end

    assign out_valid = r_v[STAGES-1];
    assign dout      = r_d[STAGES-1];
  end

endmodule

`default_nettype wire

// File: rtl/outbuf_deskew.sv
//------------------------------------------------------------------------------
// Module  : outbuf_deskew
// Brief   : Per-column output deskew delay followed by a drainable result FIFO.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module outbuf_deskew
  import buf_pkg::*;
#(
  parameter int WIDTH   = BUF_WIDTH_DEF,
  parameter int DEPTH   = BUF_DEPTH_DEF,
  parameter int PADDING = 0,
  parameter int MAXPAD  = BUF_MAXPAD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         din,
  input  logic                     flush,
  input  logic                     read,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     empty,
  output logic                     full,
  output logic [ptr_w(DEPTH)-1:0]  count,
  output logic                     overflow
);

  localparam int c_pw     = ptr_w(DEPTH);
  localparam int c_aw     = $clog2(DEPTH);
  localparam int c_stages = MAXPAD - PADDING;

  if (PADDING > MAXPAD || PADDING < 0) begin : g_err_pad
    $error("outbuf_deskew: PADDING must lie in 0..MAXPAD");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth
    $error("outbuf_deskew: DEPTH must be a power of 2 and >= 2");
  end

  logic             w_aval;
  logic [WIDTH-1:0] w_adata;

  deskew_line #(
    .WIDTH  (WIDTH),
    .STAGES (c_stages)
  ) u_line (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .in_valid  (in_valid),
    .din       (din),
    .out_valid (w_aval),
    .dout      (w_adata)
  );

  logic [c_pw-1:0]  r_wptr;
  logic [c_pw-1:0]  r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic [c_pw-1:0]  w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_rd;
  logic             w_wr;

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == c_pw'(DEPTH));
  assign w_rd    = read && !w_empty;
  // A read on the same edge frees a slot, so a full FIFO may still accept.
  assign w_wr    = w_aval && (!w_full || w_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (flush) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_dout_valid <= w_rd;
      if (w_rd) begin
        r_dout <= r_mem[r_rptr[c_aw-1:0]];
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_aval && !w_wr) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr) r_mem[r_wptr[c_aw-1:0]] <= w_adata;
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = w_count;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_outbuf_deskew.sv
//------------------------------------------------------------------------------
// Module  : tb_outbuf_deskew
// Brief   : Three columns (PADDING 0/3/7) checked against a queue-based model.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_outbuf_deskew;

  logic       clk;
  logic       rst;
  logic       iv  [3];
  logic [7:0] dn  [3];
  logic       rd  [3];
  logic       fl  [3];
  logic [7:0] dout_a [3];
  logic       dv_a   [3];
  logic       emp    [3];
  logic       ful    [3];
  logic [3:0] cnt    [3];
  logic       ovf_a  [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dly [3] = '{7, 4, 0};

  typedef struct { int due; logic [7:0] d; } sch_t;
  sch_t       msch  [3][$];
  logic [7:0] mf    [3][$];
  logic [7:0] mdout [3];
  logic       mdv   [3];
  logic       movf  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  outbuf_deskew #(.WIDTH(8), .DEPTH(8), .PADDING(0), .MAXPAD(7)) u_p0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .din(dn[0]), .flush(fl[0]), .read(rd[0]),
    .dout(dout_a[0]), .dout_valid(dv_a[0]), .empty(emp[0]), .full(ful[0]),
    .count(cnt[0]), .overflow(ovf_a[0]));
  outbuf_deskew #(.WIDTH(8), .DEPTH(8), .PADDING(3), .MAXPAD(7)) u_p3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .din(dn[1]), .flush(fl[1]), .read(rd[1]),
    .dout(dout_a[1]), .dout_valid(dv_a[1]), .empty(emp[1]), .full(ful[1]),
    .count(cnt[1]), .overflow(ovf_a[1]));
  outbuf_deskew #(.WIDTH(8), .DEPTH(8), .PADDING(7), .MAXPAD(7)) u_p7 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .din(dn[2]), .flush(fl[2]), .read(rd[2]),
    .dout(dout_a[2]), .dout_valid(dv_a[2]), .empty(emp[2]), .full(ful[2]),
    .count(cnt[2]), .overflow(ovf_a[2]));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s col%0d: got %0h want %0h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  // Each accepted word is due at the FIFO exactly dly cycles after it was sampled.
  task automatic model(input int k);
    logic av, rdok, was_full;
    logic [7:0] ad;
    sch_t e;
    av = 1'b0; ad = '0;
    if (rst || fl[k]) begin
      msch[k].delete();
      mf[k].delete();
      mdv[k]  = 1'b0;
      movf[k] = 1'b0;
      if (rst) mdout[k] = '0;
    end else begin
      if (iv[k]) begin
        e.due = cyc + dly[k];
        e.d   = dn[k];
        msch[k].push_back(e);
      end
      if (msch[k].size() > 0 && msch[k][0].due == cyc) begin
        e  = msch[k].pop_front();
        av = 1'b1;
        ad = e.d;
      end
      was_full = (mf[k].size() == 8);
      rdok     = rd[k] && (mf[k].size() > 0);
      mdv[k]   = rdok;
      if (rdok) mdout[k] = mf[k].pop_front();
      if (av) begin
        if (!was_full || rdok) mf[k].push_back(ad);
        else movf[k] = 1'b1;
      end
    end
  endtask

  task automatic compare(input int k);
    chk("count",    k, 32'(cnt[k]),   32'(mf[k].size()));
    chk("empty",    k, 32'(emp[k]),   32'(mf[k].size() == 0));
    chk("full",     k, 32'(ful[k]),   32'(mf[k].size() == 8));
    chk("overflow", k, 32'(ovf_a[k]), 32'(movf[k]));
    chk("dv",       k, 32'(dv_a[k]),  32'(mdv[k]));
    chk("dout",     k, 32'(dout_a[k]), 32'(mdout[k]));
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model(k);
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) compare(k);
  endtask

  task automatic idle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; dn[k] = '0; rd[k] = 1'b0; fl[k] = 1'b0;
    end
  endtask

  typedef struct {
    logic iv; logic [7:0] din; logic rd; logic fl;
    logic [3:0] cnt; logic full; logic ovf; logic dv; logic [7:0] dout;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input logic v, input logic [7:0] d, input logic r, input logic f,
                     input logic [3:0] c, input logic fu, input logic o, input logic q,
                     input logic [7:0] od);
    vec_t x;
    x.iv = v; x.din = d; x.rd = r; x.fl = f;
    x.cnt = c; x.full = fu; x.ovf = o; x.dv = q; x.dout = od;
    tbl.push_back(x);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) chk("reset_empty", k, 32'(emp[k]), 32'd1);
    idle();

    // Single word through the 7-stage column.
    iv[0] = 1'b1; dn[0] = 8'h01;
    for (int t = 0; t <= 6; t++) begin
      step();
      idle();
      chk("t1_empty_early", 0, 32'(emp[0]), 32'd1);
    end
    step();
    chk("t1_empty_fall", 0, 32'(emp[0]), 32'd0);
    step();
    rd[0] = 1'b1;
    step();
    idle();
    chk("t1_dv", 0, 32'(dv_a[0]), 32'd1);
    chk("t1_dout", 0, 32'(dout_a[0]), 32'h01);
    step();

    // Staggered columns must align on the same edge.
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 3; k++) begin
        int p, idx;
        p   = (k == 0) ? 0 : (k == 1) ? 3 : 7;
        idx = t - p;
        iv[k] = (idx >= 0 && idx < 5);
        dn[k] = (idx >= 0 && idx < 5) ? 8'(idx + 1) : 8'h00;
      end
      step();
      for (int k = 0; k < 3; k++) chk("t2_align_empty", k, 32'(emp[k]), 32'(t < 7));
    end
    idle();
    for (int j = 1; j <= 5; j++) begin
      for (int k = 0; k < 3; k++) rd[k] = 1'b1;
      step();
      for (int k = 0; k < 3; k++) chk("t2_pop", k, 32'(dout_a[k]), 32'(j));
    end
    idle();
    step();

    // Table: fill/overflow/drain, flush, then full with simultaneous read+write.
    rst = 1'b1;
    step();
    idle();
    for (int i = 1; i <= 10; i++)
      add(1, 8'(i), 0, 0, 4'((i > 8) ? 8 : i), i >= 8, i >= 9, 0, 8'h00);
    for (int i = 1; i <= 8; i++)
      add(0, 8'h00, 1, 0, 4'(8 - i), 0, 1, 1, 8'(i));
    add(0, 8'h00, 1, 0, 4'd0, 0, 1, 0, 8'h08);
    add(0, 8'h00, 0, 1, 4'd0, 0, 0, 0, 8'h08);
    for (int i = 1; i <= 8; i++)
      add(1, 8'(8'h10 + i), 0, 0, 4'(i), i == 8, 0, 0, 8'h08);
    add(1, 8'h55, 1, 0, 4'd8, 1, 0, 1, 8'h11);
    for (int i = 2; i <= 8; i++)
      add(0, 8'h00, 1, 0, 4'(9 - i), 0, 0, 1, 8'(8'h10 + i));
    add(0, 8'h00, 1, 0, 4'd0, 0, 0, 1, 8'h55);
    for (int i = 0; i < tbl.size(); i++) begin
      iv[2] = tbl[i].iv; dn[2] = tbl[i].din; rd[2] = tbl[i].rd; fl[2] = tbl[i].fl;
      step();
      chk("tbl_count", 2, 32'(cnt[2]),    32'(tbl[i].cnt));
      chk("tbl_empty", 2, 32'(emp[2]),    32'(tbl[i].cnt == 0));
      chk("tbl_full",  2, 32'(ful[2]),    32'(tbl[i].full));
      chk("tbl_ovf",   2, 32'(ovf_a[2]),  32'(tbl[i].ovf));
      chk("tbl_dv",    2, 32'(dv_a[2]),   32'(tbl[i].dv));
      chk("tbl_dout",  2, 32'(dout_a[2]), 32'(tbl[i].dout));
    end
    idle();

    // Flush with 3 words stored and 2 still in the delay line.
    for (int t = 0; t < 7; t++) begin
      iv[1] = (t < 5);
      dn[1] = 8'(8'hA1 + t);
      step();
    end
    idle();
    chk("t5_pre_count", 1, 32'(cnt[1]), 32'd3);
    fl[1] = 1'b1;
    step();
    idle();
    chk("t5_count", 1, 32'(cnt[1]), 32'd0);
    chk("t5_empty", 1, 32'(emp[1]), 32'd1);
    chk("t5_dv",    1, 32'(dv_a[1]), 32'd0);
    for (int t = 0; t < 8; t++) begin
      step();
      chk("t5_quiet", 1, 32'(emp[1]), 32'd1);
    end

    // Reads while empty, then reset with entries stored.
    rd[2] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("t6_dv_empty", 2, 32'(dv_a[2]), 32'd0);
    end
    rd[2] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      iv[2] = 1'b1; dn[2] = 8'(8'h60 + t);
      step();
    end
    chk("t6_pre_count", 2, 32'(cnt[2]), 32'd4);
    rst = 1'b1; rd[2] = 1'b1;
    step();
    idle();
    chk("t6_count", 2, 32'(cnt[2]),    32'd0);
    chk("t6_dout",  2, 32'(dout_a[2]), 32'd0);
    chk("t6_empty", 2, 32'(emp[2]),    32'd1);

    // Randomised traffic: slow drain first to provoke overflow, then fast drain.
    for (int t = 0; t < 800; t++) begin
      int rpct;
      rpct = (t < 400) ? 20 : 70;
      rst  = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 3; k++) begin
        iv[k] = ($urandom_range(0, 99) < 60);
        dn[k] = 8'($urandom);
        rd[k] = ($urandom_range(0, 99) < rpct);
        fl[k] = ($urandom_range(0, 99) < 2);
      end
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
